// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file round-robin controller.
// Command and response-tag structs sized for the 8x8 register file.
// No logic here; widths track the default array geometry.
package rf_arb_pkg;

  localparam int AW      = 3;
  localparam int DW      = 8;
  localparam int DEPTH   = 8;
  // Wide enough for up to four requesters.
  localparam int IDW_MAX = 2;

  typedef struct packed {
    logic               we;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [IDW_MAX-1:0] id;
  } rf_cmd_t;

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Latency: grant is combinational; the pointer advances on the accepting edge.
// Backpressure: none; a grant is offered whenever any request is present.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic          w_found;

  // Two passes: requesters at/above the pointer first, then wrap to the low ones.
  always_comb begin
    o_grant = '0;
    w_next  = r_ptr;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i] && (i >= int'(r_ptr))) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        w_next     = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        w_next     = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Pointer moves just past the winner on accept; holds while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_accept && w_found) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/rf_rr_arbiter.sv
// Shares one single-port 8x8 register file between NREQ requesters, round-robin.
// Latency: command issued to the array 1 cycle after accept; read response 2 cycles after accept.
// Backpressure: none; one command accepted per cycle. Optional: RF_ARB_UNWRITTEN_CHECK_EN adds rsp_uninit.
module rf_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = rf_arb_pkg::AW,
  parameter int DW   = rf_arb_pkg::DW,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rf_wr,
  output logic               rf_rd,
  output logic [AW-1:0]      rf_addr,
  output logic [DW-1:0]      rf_din,
  input  logic [DW-1:0]      rf_dout,
  input  logic               rf_error,
`ifdef RF_ARB_UNWRITTEN_CHECK_EN
  output logic               rsp_uninit,
`endif
  output logic               err_sticky
);

  import rf_arb_pkg::*;

  logic [NREQ-1:0] w_grant;
  logic            w_any;
  logic            w_accept;
  rf_cmd_t         w_cmd;

  logic            r_wr;
  logic            r_rd;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_din;
  rsp_tag_t        r_tag1;
  rsp_tag_t        r_tag2;
  logic            r_err;
  logic            w_unused_tag_id;

  assign w_any = |req_valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (req_valid),
    .i_accept (w_any),
    .o_grant  (w_grant)
  );

  // Grants are forced low while reset is held so the port reads idle immediately.
  assign req_ready = resetn ? w_grant : '0;
  assign w_accept  = |w_grant;

  // Select the winning requester's command fields.
  always_comb begin
    w_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_cmd.we    = req_we[i];
        w_cmd.addr  = req_addr[i*AW +: AW];
        w_cmd.wdata = req_wdata[i*DW +: DW];
        w_cmd.id    = IDW_MAX'(i);
      end
    end
  end

  // Drive the array port from flops; wr and rd are mutually exclusive by construction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_wr <= w_accept & w_cmd.we;
      r_rd <= w_accept & ~w_cmd.we;
      if (w_accept) begin
        r_addr <= w_cmd.addr;
        r_din  <= w_cmd.wdata;
      end
    end
  end

  // Tag pipeline lines up the requester ID with the array's registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1.valid <= w_accept & ~w_cmd.we;
      r_tag1.id    <= w_cmd.id;
      r_tag2       <= r_tag1;
    end
  end

  // Any array error is latched until reset; the array only flags wr&rd, which we never drive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | rf_error;
    end
  end

`ifdef RF_ARB_UNWRITTEN_CHECK_EN
  logic [DEPTH-1:0] r_written;
  logic             r_uninit;

  // Bitmap marks issued writes; a read samples it on its issue cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_written <= '0;
      r_uninit  <= 1'b0;
    end else begin
      if (r_wr) begin
        r_written[r_addr] <= 1'b1;
      end
      r_uninit <= r_tag1.valid & ~r_written[r_addr];
    end
  end

  assign rsp_uninit = r_uninit;
`endif

  assign rf_wr      = r_wr;
  assign rf_rd      = r_rd;
  assign rf_addr    = r_addr;
  assign rf_din     = r_din;
  assign rsp_valid  = r_tag2.valid;
  assign rsp_id     = r_tag2.id[IDW-1:0];
  assign rsp_rdata  = rf_dout;
  assign err_sticky = r_err;

  // Upper ID bits are spare when fewer than four requesters are configured.
  assign w_unused_tag_id = ^r_tag2.id;

endmodule

// File: doc/rf_rr_arbiter.md
Name: rf_rr_arbiter

Overview:
- Round-robin controller that shares one 8x8 flip-flop register file (single port: wr, rd, addr, din, registered dout, registered error) between NREQ requesters.
- Accepts at most one command per cycle through a valid/ready handshake and drives the register-file port from registered outputs.
- Never asserts wr and rd together, so the array's wr&rd error path is a should-never-happen monitor.
- Returns read data tagged with the requester ID.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 3, address width (register-file depth 8).
- DW, 8, data width.
- IDW, 1, requester ID width; equals $clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- rsp_valid  out  1  read data valid.
- rsp_id  out  IDW  requester that issued the read.
- rsp_rdata  out  DW  read data.
- rf_wr  out  1  register-file write strobe.
- rf_rd  out  1  register-file read strobe.
- rf_addr  out  AW  register-file address.
- rf_din  out  DW  register-file write data.
- rf_dout  in  DW  register-file registered read data.
- rf_error  in  1  register-file registered error flag.
- err_sticky  out  1  latched when rf_error is seen high.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset resetn is asynchronous and active-low.
  - All flops clear immediately on resetn=0.
- Reset values:
  - req_ready=0, rf_wr=0, rf_rd=0, rf_addr=0, rf_din=0.
  - rsp_valid=0, rsp_id=0, err_sticky=0.
  - Round-robin pointer = 0; response pipeline empty.
- Arbitration (combinational, cycle T):
  - Grant the first requester with req_valid=1, searching from pointer upward with wrap-around.
  - req_ready[g]=1 for the winner only.
  - req_ready=0 everywhere when no request is pending.
  - req_ready does not depend on rsp or on history beyond the pointer; no backpressure path.
- Pointer:
  - On accept, pointer <= (g+1) mod NREQ.
  - Unchanged when idle.
  - Requester NREQ-1 granted -> pointer wraps to 0.
- Issue (cycle T+1, registered):
  - rf_wr=we, rf_rd=~we, rf_addr, rf_din = accepted command.
  - No accept in T -> rf_wr=rf_rd=0; rf_addr/rf_din hold their previous values.
- Read response (cycle T+2):
  - 2-stage tag pipeline {valid, id} shifts every cycle.
  - rsp_valid=1 and rsp_id=ID exactly two cycles after a read is accepted.
  - rsp_rdata = rf_dout, passed straight through.
- Latency and throughput:
  - Read latency is accept + 2 cycles.
  - Writes produce no response.
  - Throughput is 1 command per cycle; back-to-back reads give back-to-back responses.
- Write-then-read same address on consecutive accepts: the read returns the new data, because the array write lands at the end of T+1, before the read is sampled at the end of T+2.
- err_sticky:
  - Set on any cycle with rf_error=1.
  - Cleared only by reset.
- Reset mid-operation: in-flight commands and responses are dropped; no rsp_valid after reset release until a new read is accepted.
- Requester rules:
  - A requester keeps req_valid and its fields stable until req_ready.
  - The arbiter does not check this.

Optional Feature:
- Macro: RF_ARB_UNWRITTEN_CHECK_EN.
- When defined:
  - Adds an 8-bit written bitmap, cleared at reset.
  - A bit is set when a write is issued to that address.
  - Adds output rsp_uninit (1 bit, reset 0), asserted alongside rsp_valid when the read targeted an address never written.
  - The bitmap is sampled at issue (T+1), so a write issued in the cycle before counts.
- When undefined: no bitmap and no rsp_uninit port.

Decomposition:
- Package rf_arb_pkg holds:
  - localparams AW=3, DW=8, DEPTH=8.
  - typedef rf_cmd_t {we, addr, wdata, id}.
  - typedef rsp_tag_t {valid, id}.
- Sub-module rr_arbiter(NREQ):
  - Inputs: request vector, accept.
  - Output: one-hot grant; holds the pointer internally.
  - Reusable elsewhere.

Test Plan:
- Reset: hold resetn=0 mid-traffic -> all outputs 0 asynchronously; after release, no rsp_valid until a new read.
- Single write then read:
  - R0 writes addr 3 = 0xA5 at T0 -> rf_wr=1, rf_addr=3, rf_din=0xA5 at T1.
  - R0 reads addr 3 at T2 -> rf_rd=1 at T3; rsp_valid=1, rsp_id=0, rsp_rdata=0xA5 at T4.
- Fairness:
  - Both requesters hold valid reads for 6 cycles -> grants alternate 0,1,0,1,0,1.
  - rsp_id alternates with 2-cycle lag.
  - rf_wr and rf_rd never both 1; err_sticky stays 0.
- Hazard: R0 writes addr 7 = 0x3C, R1 reads addr 7 in the next cycle -> rsp_rdata=0x3C, rsp_id=1.
- Error monitor: force rf_error=1 for one cycle -> err_sticky=1 and stays 1 until reset.
- With RF_ARB_UNWRITTEN_CHECK_EN:
  - Read addr 5 after reset -> rsp_uninit=1.
  - Write addr 5, then read -> rsp_uninit=0.
